// File: rtl/glitch_trigger_delay.sv
// Trigger-to-glitch delay stage: synchronises trig_in, waits a programmable delay after the
// selected edge, then gates the glitch generator. GLITCH_TRIGGER_DELAY_SWEEP_EN adds a per-run delay offset.
module glitch_trigger_delay #(
    parameter int DELAY_W        = 16,
    parameter int LEN_W          = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_in,
    input  logic               trig_edge_sel,
    input  logic [DELAY_W-1:0] delay_val,
    input  logic [LEN_W-1:0]   glitch_len,
    output logic               glitch_gate,
    output logic [LEN_W-1:0]   glitch_len_out,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic [15:0]        fire_count,
    output logic [2:0]         state_dbg
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        FIRE    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_s;
    logic                   trig_prev;
    logic                   edge_sel_q;
    logic                   edge_hit;
    logic [DELAY_W-1:0]     delay_q;
    logic [DELAY_W-1:0]     delay_eff;
    logic [DELAY_W-1:0]     delay_cnt;
    logic [LEN_W-1:0]       len_cnt;
    logic [HOLD_W-1:0]      hold_cnt;

    assign trig_s    = sync_q[SYNC_STAGES-1];
    assign edge_hit  = edge_sel_q ? (~trig_s & trig_prev) : (trig_s & ~trig_prev);
    assign armed     = (state == ARMED);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

`ifdef GLITCH_TRIGGER_DELAY_SWEEP_EN
    logic [DELAY_W-1:0] sweep_off;
    logic [DELAY_W:0]   delay_sum;

    assign delay_sum = {1'b0, delay_val} + {1'b0, sweep_off};
    assign delay_eff = delay_sum[DELAY_W] ? {DELAY_W{1'b1}} : delay_sum[DELAY_W-1:0];

    // Offset advances once per completed run; an aborted run starts the sweep over.
    always_ff @(posedge clk_in) begin
        if (reset || abort) begin
            sweep_off <= '0;
        end else if (state == HOLDOFF && hold_cnt == '0) begin
            sweep_off <= sweep_off + DELAY_W'(1);
        end
    end
`else
    assign delay_eff = delay_val;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
        end
    end

    // Handshake: arm is a one-cycle request honoured only while busy is low; done is the
    // one-cycle completion pulse and is never raised for a run that ends by abort.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state          <= IDLE;
            trig_prev      <= 1'b0;
            edge_sel_q     <= 1'b0;
            delay_q        <= '0;
            delay_cnt      <= '0;
            len_cnt        <= '0;
            hold_cnt       <= '0;
            glitch_gate    <= 1'b0;
            glitch_len_out <= '0;
            done           <= 1'b0;
            fire_count     <= '0;
        end else begin
            // Tracking every cycle also reloads the history on the arm cycle, so a level
            // already present when arming never counts as an edge.
            trig_prev <= trig_s;
            if (abort) begin
                state       <= IDLE;
                glitch_gate <= 1'b0;
                done        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        done <= 1'b0;
                        if (arm) begin
                            delay_q        <= delay_eff;
                            glitch_len_out <= glitch_len;
                            edge_sel_q     <= trig_edge_sel;
                            state          <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (edge_hit) begin
                            if (delay_q == '0) begin
                                state       <= FIRE;
                                len_cnt     <= glitch_len_out;
                                glitch_gate <= (glitch_len_out != '0);
                                if (glitch_len_out != '0) begin
                                    fire_count <= fire_count + 16'd1;
                                end
                            end else begin
                                delay_cnt <= delay_q;
                                state     <= DELAY;
                            end
                        end
                    end
                    DELAY: begin
                        if (delay_cnt == DELAY_W'(1)) begin
                            state       <= FIRE;
                            len_cnt     <= glitch_len_out;
                            glitch_gate <= (glitch_len_out != '0);
                            if (glitch_len_out != '0) begin
                                fire_count <= fire_count + 16'd1;
                            end
                        end
                        delay_cnt <= delay_cnt - DELAY_W'(1);
                    end
                    FIRE: begin
                        // A zero length still spends one cycle here with the gate low.
                        if (len_cnt <= LEN_W'(1)) begin
                            glitch_gate <= 1'b0;
                            hold_cnt    <= HOLD_W'(HOLDOFF_CYCLES - 1);
                            done        <= (HOLDOFF_CYCLES == 1);
                            state       <= HOLDOFF;
                        end else begin
                            len_cnt <= len_cnt - LEN_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (hold_cnt == '0) begin
                            done  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            done     <= (hold_cnt == HOLD_W'(1));
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        glitch_gate <= 1'b0;
                        done        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
